// File: rtl/core_pkg.sv
// Shared decode definitions for the single-cycle RV32I core: opcodes, ALU ops,
// immediate formats, writeback select and the immediate generator.
package core_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_PC4
    } wb_sel_e;

    function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'b0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/core_regfile.sv
// 32x32 register file, two asynchronous read ports and one synchronous write port.
// REGFILE_RESET_EN adds a synchronous clear of all registers on rst.
module core_regfile
    import core_pkg::*;
(
    input  logic        clk,
`ifdef REGFILE_RESET_EN
    input  logic        rst,
`endif
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] regs_q [32];

`ifdef REGFILE_RESET_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end
`endif

    // Entry 0 is never written; x0 is forced to zero on the read side.
    assign rdata1_o = (raddr1_i == 5'd0) ? 32'h0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? 32'h0 : regs_q[raddr2_i];

endmodule

// File: rtl/core.sv
// Single-cycle RV32I core: combinational decode/ALU/branch, pc and rd commit on clk.
// Optional macro REGFILE_RESET_EN clears the register file on rst.
module core
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] dataR,
    output logic [31:0] pc,
    output logic [31:0] alu_result,
    output logic [31:0] DataWM,
    output logic        MemWrite,
    output logic        MemRead
);

    logic [31:0] pc_q, pc_d;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;

    alu_op_e     alu_op;
    imm_fmt_e    imm_fmt;
    wb_sel_e     wb_sel;
    logic        a_is_pc, b_is_imm, rf_we, mem_rd, mem_wr;
    logic        is_branch, is_jal, is_jalr, br_taken;

    logic [31:0] rs1_val, rs2_val, imm, op_a, op_b, alu_y, wb_data, pc_plus4;
    logic signed [31:0] op_a_s, op_b_s;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

    always_comb begin
        alu_op    = ALU_ADD;
        imm_fmt   = IMM_I;
        wb_sel    = WB_ALU;
        a_is_pc   = 1'b0;
        b_is_imm  = 1'b0;
        rf_we     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        case (opcode)
            OP: begin
                rf_we = 1'b1;
                case (funct3)
                    3'b000:  alu_op = instr[30] ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = instr[30] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            OP_IMM: begin
                rf_we    = 1'b1;
                b_is_imm = 1'b1;
                case (funct3)
                    3'b000:  alu_op = ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = instr[30] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            LOAD: begin
                if (funct3 == 3'b010) begin
                    b_is_imm = 1'b1;
                    mem_rd   = 1'b1;
                    rf_we    = 1'b1;
                    wb_sel   = WB_MEM;
                end
            end
            STORE: begin
                if (funct3 == 3'b010) begin
                    imm_fmt  = IMM_S;
                    b_is_imm = 1'b1;
                    mem_wr   = 1'b1;
                end
            end
            BRANCH: begin
                imm_fmt   = IMM_B;
                alu_op    = ALU_SUB;
                is_branch = 1'b1;
            end
            JAL: begin
                imm_fmt  = IMM_J;
                a_is_pc  = 1'b1;
                b_is_imm = 1'b1;
                rf_we    = 1'b1;
                wb_sel   = WB_PC4;
                is_jal   = 1'b1;
            end
            JALR: begin
                b_is_imm = 1'b1;
                rf_we    = 1'b1;
                wb_sel   = WB_PC4;
                is_jalr  = 1'b1;
            end
            LUI: begin
                imm_fmt  = IMM_U;
                b_is_imm = 1'b1;
                rf_we    = 1'b1;
                alu_op   = ALU_PASSB;
            end
            AUIPC: begin
                imm_fmt  = IMM_U;
                a_is_pc  = 1'b1;
                b_is_imm = 1'b1;
                rf_we    = 1'b1;
            end
            default: ;
        endcase
    end

    assign imm    = imm_gen(instr, imm_fmt);
    assign op_a   = a_is_pc ? pc_q : rs1_val;
    assign op_b   = b_is_imm ? imm : rs2_val;
    assign op_a_s = op_a;
    assign op_b_s = op_b;

    always_comb begin
        case (alu_op)
            ALU_ADD:   alu_y = op_a + op_b;
            ALU_SUB:   alu_y = op_a - op_b;
            ALU_SLL:   alu_y = op_a << op_b[4:0];
            ALU_SLT:   alu_y = {31'b0, (op_a_s < op_b_s)};
            ALU_SLTU:  alu_y = {31'b0, (op_a < op_b)};
            ALU_XOR:   alu_y = op_a ^ op_b;
            ALU_SRL:   alu_y = op_a >> op_b[4:0];
            ALU_SRA:   alu_y = op_a_s >>> op_b[4:0];
            ALU_OR:    alu_y = op_a | op_b;
            ALU_AND:   alu_y = op_a & op_b;
            ALU_PASSB: alu_y = op_b;
            default:   alu_y = 32'h0;
        endcase
    end

    // Branch compare works on the register operands, independent of the ALU.
    always_comb begin
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_taken = (rs1_val <  rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d = pc_plus4;
        if (is_jal) begin
            pc_d = alu_y;
        end else if (is_jalr) begin
            pc_d = alu_y & ~32'd1;
        end else if (is_branch && br_taken) begin
            pc_d = pc_q + imm;
        end
    end

    always_comb begin
        case (wb_sel)
            WB_MEM:  wb_data = dataR;
            WB_PC4:  wb_data = pc_plus4;
            default: wb_data = alu_y;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    core_regfile u_regfile (
        .clk      (clk),
`ifdef REGFILE_RESET_EN
        .rst      (rst),
`endif
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rs1_val),
        .rdata2_o (rs2_val),
        .we_i     (rf_we & ~rst),
        .waddr_i  (rd),
        .wdata_i  (wb_data)
    );

    assign pc         = pc_q;
    assign alu_result = alu_y;
    assign DataWM     = rs2_val;
    assign MemWrite   = mem_wr & ~rst;
    assign MemRead    = mem_rd & ~rst;

endmodule

// File: tb/tb_core.sv
// Directed-vector bench for core: each instruction is applied after a rising
// edge and its outputs are checked on the following falling edge.
module tb_core;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] dataR;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] DataWM;
    logic        MemWrite;
    logic        MemRead;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    core #(.RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .dataR      (dataR),
        .pc         (pc),
        .alu_result (alu_result),
        .DataWM     (DataWM),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Commit the previous instruction, present a new one, settle to the falling edge.
    task automatic exec(input logic [31:0] ins, input logic [31:0] dr);
        @(posedge clk);
        #1;
        instr = ins;
        dataR = dr;
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        instr = 32'h00302023;
        dataR = 32'h0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_memwrite", {31'b0, MemWrite}, 32'h0);
        instr = 32'h00002283;
        #1;
        chk("rst_memread", {31'b0, MemRead}, 32'h0);

        @(posedge clk);
        #1;
        rst   = 1'b0;
        instr = NOP;
        @(negedge clk);
        chk("pc0", pc, 32'h0);
        exec(NOP, 32'h0);
        chk("pc4", pc, 32'h4);
        exec(NOP, 32'h0);
        chk("pc8", pc, 32'h8);

        exec(32'h00500093, 32'h0);           // addi x1,x0,5 @12
        chk("addi5", alu_result, 32'd5);
        chk("pc12", pc, 32'd12);
        exec(32'h00a00113, 32'h0);           // addi x2,x0,10
        chk("addi10", alu_result, 32'd10);
        exec(32'h002081b3, 32'h0);           // add x3,x1,x2
        chk("add15", alu_result, 32'd15);
        exec(32'h00302023, 32'h0);           // sw x3,0(x0) @24
        chk("sw_we", {31'b0, MemWrite}, 32'h1);
        chk("sw_re", {31'b0, MemRead}, 32'h0);
        chk("sw_addr", alu_result, 32'h0);
        chk("sw_data", DataWM, 32'd15);
        exec(32'h00002283, 32'hABCD1234);    // lw x5,0(x0) @28
        chk("lw_re", {31'b0, MemRead}, 32'h1);
        chk("lw_we", {31'b0, MemWrite}, 32'h0);
        chk("lw_addr", alu_result, 32'h0);
        exec(32'h00028333, 32'h0);           // add x6,x5,x0 @32
        chk("lw_value", alu_result, 32'hABCD1234);
        chk("pc32", pc, 32'd32);

        exec(32'h00001463, 32'h0);           // bne x0,x0,+8 @36 -> not taken
        exec(32'hFE000CE3, 32'h0);           // beq x0,x0,-8 @40 -> 32
        chk("bne_nt_pc", pc, 32'd40);
        exec(32'h00700013, 32'h0);           // addi x0,x0,7 @32
        chk("beq_pc", pc, 32'd32);
        chk("addi_x0_alu", alu_result, 32'd7);
        exec(32'h000003b3, 32'h0);           // add x7,x0,x0
        chk("x0_zero", alu_result, 32'h0);
        exec(32'h40110433, 32'h0);           // sub x8,x2,x1
        chk("sub", alu_result, 32'd5);
        exec(32'hFFF00493, 32'h0);           // addi x9,x0,-1
        chk("addi_m1", alu_result, 32'hFFFFFFFF);
        exec(32'h0090B533, 32'h0);           // sltu x10,x1,x9
        chk("sltu", alu_result, 32'd1);
        exec(32'h0090A5B3, 32'h0);           // slt x11,x1,x9
        chk("slt", alu_result, 32'd0);
        exec(32'h4044D613, 32'h0);           // srai x12,x9,4
        chk("srai", alu_result, 32'hFFFFFFFF);
        exec(32'h0044D693, 32'h0);           // srli x13,x9,4
        chk("srli", alu_result, 32'h0FFFFFFF);
        chk("pc60", pc, 32'd60);
        exec(32'h00408767, 32'h0);           // jalr x14,4(x1) @64 -> 8
        chk("jalr_sum", alu_result, 32'd9);
        exec(32'h000707B3, 32'h0);           // add x15,x14,x0 @8
        chk("jalr_pc", pc, 32'd8);
        chk("jalr_link", alu_result, 32'd68);
        exec(32'h12345837, 32'h0);           // lui x16,0x12345 @12
        chk("lui", alu_result, 32'h12345000);
        exec(32'h00001897, 32'h0);           // auipc x17,1 @16
        chk("auipc", alu_result, 32'h00001010);
        exec(32'h00000903, 32'h0);           // lb: illegal width -> NOP
        chk("lb_nop_re", {31'b0, MemRead}, 32'h0);
        exec(NOP, 32'h0);
        chk("lb_nop_pc", pc, 32'd24);

        @(posedge clk);
        #1;
        rst   = 1'b1;
        instr = NOP;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        instr = 32'h00C000EF;                // jal x1,+12 @0
        @(negedge clk);
        chk("rst2_pc", pc, 32'h0);
        exec(32'h000089B3, 32'h0);           // add x19,x1,x0 @12
        chk("jal_pc", pc, 32'd12);
        chk("jal_link", alu_result, 32'd4);
        exec(32'h00010A33, 32'h0);           // add x20,x2,x0
`ifdef REGFILE_RESET_EN
        chk("x2_after_rst", alu_result, 32'd0);
`else
        chk("x2_after_rst", alu_result, 32'd10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
